tx_buffer_fifo_4: RTL

Four-word transmit-side buffer: the egress counterpart of the 2-word receive buffer. It accepts parallel words from the framing logic under a ready/valid handshake and hands them to the lane transmitter on request pulses. On an empty request it substitutes a parameterised idle word, so the transmitter always receives exactly one `dout_valid` pulse per request. Sits between the TX framer and the serializer/lane mux, in the single `clk` domain.

---
 rtl/tx_buffer_pkg.sv | 8 +
 rtl/tx_buffer_fifo_4.sv | 82 ++++++++
 2 files changed

// File: rtl/tx_buffer_pkg.sv
// Shared sizing constants for the four-entry transmit buffer.
package tx_buffer_pkg;

  localparam int unsigned TXB_DEPTH  = 4;
  localparam int unsigned TXB_PTR_W  = 3;
  localparam int unsigned TXB_ADDR_W = TXB_PTR_W - 1;

endpackage

// File: rtl/tx_buffer_fifo_4.sv
// Four-word egress buffer between the TX framer and the lane transmitter;
// every dout_req yields exactly one dout_valid pulse, with idle filler when empty.
module tx_buffer_fifo_4
  import tx_buffer_pkg::*;
#(
  parameter int unsigned      WIDTH     = 400,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic                 dout_req,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 dout_idle,
  output logic                 underflow,
  output logic                 overflow,
  output logic [TXB_PTR_W-1:0] fill
);

  logic [TXB_PTR_W-1:0] wr_ptr;
  logic [TXB_PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0]     mem [TXB_DEPTH];
  logic                 full;
  logic                 empty;
  logic                 wr_en;
  logic                 rd_en;

  // Wrap bit distinguishes full from empty when addresses coincide.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[TXB_ADDR_W-1:0] == rd_ptr[TXB_ADDR_W-1:0]) &&
                     (wr_ptr[TXB_PTR_W-1] != rd_ptr[TXB_PTR_W-1]);
  assign din_ready = ~full;
  assign fill      = wr_ptr - rd_ptr;

  assign wr_en = din_valid & ~full  & ~flush;
  assign rd_en = dout_req  & ~empty & ~flush;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[TXB_ADDR_W-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_idle  <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else if (flush) begin
      // Coincident request is dropped; dout/dout_idle keep their last value.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      dout_valid <= 1'b0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + TXB_PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + TXB_PTR_W'(1);
      end
      dout_valid <= dout_req;
      underflow  <= dout_req & empty;
      overflow   <= din_valid & full;
      if (dout_req) begin
        dout      <= empty ? IDLE_WORD : mem[rd_ptr[TXB_ADDR_W-1:0]];
        dout_idle <= empty;
      end
    end
  end

endmodule
